// File: rtl/sw_p_if.sv
// CPU register-port bundle for the switch/button peripheral.
// The CPU side drives the master modport; the peripheral sits on the slave modport.
interface sw_p_if;
  logic        wea;
  logic [3:0]  addra;
  logic [31:0] dina;
  logic [31:0] douta;

  modport master (output wea, addra, dina, input douta);
  modport slave  (input wea, addra, dina, output douta);
endinterface

// File: rtl/sw_p.sv
// Slide-switch / push-button peripheral: synchronise, debounce on a slow sample tick,
// detect button presses and expose state, sticky press latch and press counter to a CPU.
module sw_p #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  sw_p_if.slave       bus,
  input  logic [15:0] sw,
  input  logic [4:0]  btn
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [20:0]   meta_q, sync_q;
  logic [20:0]   h0_q, h1_q, h2_q;
  logic [20:0]   h0_d, h1_d, h2_d;
  logic [20:0]   deb_q, deb_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [4:0]    latch_q, latch_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          en_q, en_d;
  logic [31:0]   douta_q, douta_d;

  logic          tick;
  logic [20:0]   stable, upd;
  logic [4:0]    press;
  logic          wr_latch, wr_cnt, wr_en;

  assign tick   = (tick_q == TICK_LAST);
  assign tick_d = tick ? '0 : tick_q + CW'(1);

  always_comb begin
    h0_d = h0_q;
    h1_d = h1_q;
    h2_d = h2_q;
    if (tick) begin
      h0_d = sync_q;
      h1_d = h0_q;
      h2_d = h1_q;
    end
  end

  // A bit flips only once its whole sample history agrees on the opposite value.
  assign stable = ~(h0_q ^ h1_q) & ~(h1_q ^ h2_q);
  assign upd    = stable & (h0_q ^ deb_q);
  assign deb_d  = deb_q ^ upd;
  assign press  = upd[20:16] & h0_q[20:16];

  assign wr_latch = bus.wea && (bus.addra == 4'd2);
  assign wr_cnt   = bus.wea && (bus.addra == 4'd3);
  assign wr_en    = bus.wea && (bus.addra == 4'd4);

  // Set is applied after the W1C clear so a coincident press survives.
  always_comb begin
    latch_d = latch_q;
    if (wr_latch) latch_d = latch_d & ~bus.dina[4:0];
    if (en_q)     latch_d = latch_d | press;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wr_cnt)                 cnt_d = bus.dina;
    else if (en_q && (|press))  cnt_d = cnt_q + 32'd1;
  end

  assign en_d = wr_en ? bus.dina[0] : en_q;

  always_comb begin
    douta_d = '0;
    case (bus.addra)
      4'd0:    douta_d = {16'b0, deb_q[15:0]};
      4'd1:    douta_d = {27'b0, deb_q[20:16]};
      4'd2:    douta_d = {27'b0, latch_q};
      4'd3:    douta_d = cnt_q;
      4'd4:    douta_d = {31'b0, en_q};
      default: douta_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q  <= '0;
      sync_q  <= '0;
      h0_q    <= '0;
      h1_q    <= '0;
      h2_q    <= '0;
      deb_q   <= '0;
      tick_q  <= '0;
      latch_q <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b1;
      douta_q <= '0;
    end else begin
      meta_q  <= {btn, sw};
      sync_q  <= meta_q;
      h0_q    <= h0_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      deb_q   <= deb_d;
      tick_q  <= tick_d;
      latch_q <= latch_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      douta_q <= douta_d;
    end
  end

  assign bus.douta = douta_q;

endmodule

// File: tb/tb_sw_p.sv
// Self-checking bench for sw_p: directed scenarios plus randomized traffic checked
// against a behavioural model of the debounce/press/register rules.
module tb_sw_p;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] sw  = '0;
  logic [4:0]  btn = '0;
  int          errors = 0;
  int          checks = 0;

  sw_p_if bus ();

  sw_p #(.DEBOUNCE_CYCLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .sw  (sw),
    .btn (btn)
  );

  always #5 clk = ~clk;

  // Behavioural model: inputs seen two edges late, sampled every N-th edge since reset.
  logic [20:0] m_pipe [0:1];
  logic [20:0] m_samp [0:2];
  logic [20:0] m_deb;
  logic [4:0]  m_latch;
  logic [31:0] m_cnt;
  logic        m_en;
  logic [31:0] m_douta;
  int          m_cyc;

  function automatic logic [31:0] m_reg(input logic [3:0] a);
    case (a)
      4'd0:    return {16'b0, m_deb[15:0]};
      4'd1:    return {27'b0, m_deb[20:16]};
      4'd2:    return {27'b0, m_latch};
      4'd3:    return m_cnt;
      4'd4:    return {31'b0, m_en};
      default: return 32'b0;
    endcase
  endfunction

  function automatic bit m_settled(input int b);
    return (m_samp[0][b] == m_samp[1][b]) && (m_samp[1][b] == m_samp[2][b]) &&
           (m_samp[0][b] != m_deb[b]);
  endfunction

  function automatic logic [4:0] m_press();
    logic [4:0] p = '0;
    for (int b = 16; b < 21; b++)
      if (m_settled(b) && m_samp[0][b]) p[b-16] = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    m_pipe[0] = '0; m_pipe[1] = '0;
    m_samp[0] = '0; m_samp[1] = '0; m_samp[2] = '0;
    m_deb = '0; m_latch = '0; m_cnt = '0; m_en = 1'b1; m_douta = '0; m_cyc = 0;
  endtask

  task automatic step();
    logic [31:0] rdv;
    logic [20:0] nd;
    logic [4:0]  pr;
    bit          tk;
    rdv = m_reg(bus.addra);
    pr  = m_press();
    nd  = m_deb;
    for (int b = 0; b < 21; b++) if (m_settled(b)) nd[b] = m_samp[0][b];
    tk  = (m_cyc % N) == (N - 1);
    @(posedge clk);
    if (rst) begin
      m_douta = rdv;
      if (tk) begin
        m_samp[2] = m_samp[1];
        m_samp[1] = m_samp[0];
        m_samp[0] = m_pipe[1];
      end
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = {btn, sw};
      if (bus.wea && bus.addra == 4'd2) m_latch = m_latch & ~bus.dina[4:0];
      if (m_en) m_latch = m_latch | pr;
      if (bus.wea && bus.addra == 4'd3) m_cnt = bus.dina;
      else if (m_en && pr != 0)         m_cnt = m_cnt + 32'd1;
      if (bus.wea && bus.addra == 4'd4) m_en = bus.dina[0];
      m_deb = nd;
      m_cyc++;
    end
    #1;
  endtask

  task automatic rd(input logic [3:0] a);
    bus.wea = 1'b0; bus.addra = a;
    step();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.wea = 1'b1; bus.addra = a; bus.dina = d;
    step();
    bus.wea = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    settle(2);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_r [0:4];
    exp_r = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
    do_reset();
    for (int a = 0; a < 5; a++) begin
      rd(4'(a));
      checks++;
      if (bus.douta !== exp_r[a]) begin
        errors++; $display("FAIL reset_reg%0d: got %h expected %h", a, bus.douta, exp_r[a]);
      end
    end
  endtask

  task automatic test_sw_debounce();
    sw = 16'hA5A5; btn = '0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      rd(4'd0);
      checks++;
      if (bus.douta !== ((i < 13) ? 32'h0 : 32'h0000A5A5)) begin
        errors++;
        $display("FAIL sw_deb_cycle%0d: got %h expected %h", i, bus.douta,
                 (i < 13) ? 32'h0 : 32'h0000A5A5);
      end
    end
  endtask

  task automatic test_btn_bounce();
    bit ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      btn[2] = ((i / 3) % 2) == 0;
      rd(4'd1);
      if (bus.douta !== 32'h0 || bus.douta !== m_douta) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL bounce_reg1: got nonzero expected %h", 32'h0); end
    btn[2] = 1'b1;
    settle(20);
    rd(4'd1);
    checks++;
    if (bus.douta !== 32'h4) begin errors++; $display("FAIL bounce_held_reg1: got %h expected %h", bus.douta, 32'h4); end
    rd(4'd2);
    checks++;
    if (bus.douta !== 32'h4) begin errors++; $display("FAIL bounce_latch: got %h expected %h", bus.douta, 32'h4); end
    rd(4'd3);
    checks++;
    if (bus.douta !== 32'h1) begin errors++; $display("FAIL bounce_count: got %h expected %h", bus.douta, 32'h1); end
  endtask

  task automatic test_w1c_race();
    bit hit = 1'b0;
    btn[2] = 1'b0;
    settle(20);
    btn[2] = 1'b1;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (m_press()[2]) begin
        wr(4'd2, 32'h4);
        hit = 1'b1;
      end else step();
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL race_timeout: got no press expected press within 40 cycles"); end
    rd(4'd2);
    checks++;
    if (bus.douta !== 32'h4) begin errors++; $display("FAIL race_latch: got %h expected %h", bus.douta, 32'h4); end
    rd(4'd3);
    checks++;
    if (bus.douta !== 32'h2) begin errors++; $display("FAIL race_count: got %h expected %h", bus.douta, 32'h2); end
  endtask

  task automatic test_counter_wrap();
    wr(4'd3, 32'hFFFF_FFFF);
    rd(4'd3);
    checks++;
    if (bus.douta !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cnt_load: got %h expected %h", bus.douta, 32'hFFFF_FFFF); end
    btn[2] = 1'b0; settle(20);
    btn[2] = 1'b1; settle(20);
    rd(4'd3);
    checks++;
    if (bus.douta !== 32'h0) begin errors++; $display("FAIL cnt_wrap: got %h expected %h", bus.douta, 32'h0); end
    wr(4'd4, 32'h0);
    wr(4'd2, 32'h1F);
    rd(4'd4);
    checks++;
    if (bus.douta !== 32'h0) begin errors++; $display("FAIL en_clear: got %h expected %h", bus.douta, 32'h0); end
    btn[2] = 1'b0; settle(20);
    btn[2] = 1'b1; settle(20);
    rd(4'd2);
    checks++;
    if (bus.douta !== 32'h0) begin errors++; $display("FAIL dis_latch: got %h expected %h", bus.douta, 32'h0); end
    rd(4'd3);
    checks++;
    if (bus.douta !== 32'h0) begin errors++; $display("FAIL dis_count: got %h expected %h", bus.douta, 32'h0); end
    wr(4'd4, 32'hFFFF_FFFF);
    rd(4'd4);
    checks++;
    if (bus.douta !== 32'h1) begin errors++; $display("FAIL en_upper_bits: got %h expected %h", bus.douta, 32'h1); end
  endtask

  task automatic test_addr_decode();
    wr(4'd9, 32'hFFFF_FFFF);
    rd(4'd9);
    checks++;
    if (bus.douta !== 32'h0) begin errors++; $display("FAIL addr9: got %h expected %h", bus.douta, 32'h0); end
    wr(4'd0, 32'h1234_5678);
    rd(4'd0);
    checks++;
    if (bus.douta !== 32'h0000A5A5) begin errors++; $display("FAIL ro_reg0: got %h expected %h", bus.douta, 32'h0000A5A5); end
    wr(4'd3, 32'hDEAD_BEEF);
    checks++;
    if (bus.douta !== 32'h0) begin errors++; $display("FAIL pre_write: got %h expected %h", bus.douta, 32'h0); end
    rd(4'd3);
    checks++;
    if (bus.douta !== 32'hDEAD_BEEF) begin errors++; $display("FAIL post_write: got %h expected %h", bus.douta, 32'hDEAD_BEEF); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_r [1:4];
    exp_r = '{32'h0, 32'h0, 32'h0, 32'h1};
    rd(4'd3);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.douta !== 32'h0) begin errors++; $display("FAIL async_douta: got %h expected %h", bus.douta, 32'h0); end
    btn[2] = 1'b1;
    settle(2);
    rst = 1'b1;
    for (int a = 1; a < 5; a++) begin
      rd(4'(a));
      checks++;
      if (bus.douta !== exp_r[a]) begin
        errors++; $display("FAIL midrst_reg%0d: got %h expected %h", a, bus.douta, exp_r[a]);
      end
    end
    settle(20);
    rd(4'd3);
    checks++;
    if (bus.douta !== 32'h1) begin errors++; $display("FAIL held_one_press: got %h expected %h", bus.douta, 32'h1); end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) sw  = sw  ^ 16'($urandom_range(1, 16'hFFFF));
      if ($urandom_range(0, 29) == 0) btn = btn ^ 5'($urandom_range(1, 31));
      bus.addra = 4'($urandom_range(0, 15));
      bus.wea   = ($urandom_range(0, 7) == 0);
      bus.dina  = $urandom;
      if (bus.addra == 4'd4 && $urandom_range(0, 1) == 0) bus.dina[0] = 1'b1;
      step();
      checks++;
      if (bus.douta !== m_douta) begin
        errors++;
        if (bad < 10) $display("FAIL rand_cycle%0d: got %h expected %h", i, bus.douta, m_douta);
        bad++;
      end
    end
    bus.wea = 1'b0;
  endtask

  initial begin
    bus.wea = 1'b0; bus.addra = '0; bus.dina = '0;
    model_reset();
    test_reset();
    test_sw_debounce();
    test_btn_bounce();
    test_w1c_race();
    test_counter_wrap();
    test_addr_decode();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sw_p.md
SW_P -- requirements
Module: sw_p

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 100000, the sample-tick period in clk cycles (legal values ≥ 2).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port wea, input, 1 bit, CPU write enable.
REQ-005 SHALL have port addra, input, 4 bits, register index.
REQ-006 SHALL have port dina, input, 32 bits, CPU write data.
REQ-007 SHALL have port douta, output, 32 bits, registered CPU read data.
REQ-008 SHALL have port sw, input, 16 bits, asynchronous board slide switches.
REQ-009 SHALL have port btn, input, 5 bits, asynchronous board push buttons.

Function
REQ-010 SHALL pass each sw and btn bit through a two-flop synchronizer before any other use.
REQ-011 SHALL run a tick counter 0..DEBOUNCE_CYCLES-1 that wraps, asserting an internal tick for one cycle at DEBOUNCE_CYCLES-1.
REQ-012 SHALL shift the synchronized value of each of the 21 inputs into a 3-deep per-bit sample history on each tick.
REQ-013 SHALL update a debounced bit to the new value only when its 3 most recent samples are all equal and differ from it; otherwise it holds.
REQ-014 SHALL define a press as a debounced btn bit going 0->1, and detect it in the same cycle the debounced bit updates.
REQ-015 SHALL map register 0 (RO) to {16'b0, debounced sw}.
REQ-016 SHALL map register 1 (RO) to {27'b0, debounced btn}.
REQ-017 SHALL map register 2 to {27'b0, press latch}; a press sets its bit; writing 1 to a bit clears it; writing 0 leaves it unchanged.
REQ-018 SHALL map register 3 to a 32-bit press counter that increments by 1 in any cycle with at least one press, wrapping 0xFFFFFFFF->0; a write loads dina.
REQ-019 SHALL map register 4 bit 0 to latch enable (RW); when 0, presses neither set the latch nor increment the counter; bits 31:1 read 0.
REQ-020 SHALL return 0 on reads of addresses 5..15 and ignore writes to them and to registers 0 and 1.
REQ-021 SHALL register douta every cycle from addra with 1-cycle latency, independent of wea.
REQ-022 SHALL give douta the pre-write value on a same-cycle read and write of one address.
REQ-023 SHALL let set win over clear when a press and a W1C clear hit the same latch bit in one cycle.
REQ-024 SHALL let a CPU write to the counter win over a same-cycle increment.

Reset
REQ-025 SHALL, while rst=0, immediately clear douta, synchronizers, sample histories, debounced state, latch and counter to 0, set latch enable to 1, and reset the tick counter to 0.
REQ-026 SHALL, after rst deasserts mid-debounce, restart debounce from empty history, with inputs held high from reset reported after 3 ticks and a held button counted as one press.

Verification
REQ-027 SHALL verify, with DEBOUNCE_CYCLES=4 and sw=16'hA5A5 held from reset release, that a register-0 read returns 0 until 3 ticks plus 2 sync cycles have elapsed, then 0x0000A5A5.
REQ-028 SHALL verify that btn[2] toggling every 3 cycles for 40 cycles, then held 1, leaves register 1 at 0 during the toggling, then gives 0x4 on register 1, 0x4 on register 2 and 1 on register 3.
REQ-029 SHALL verify that writing 0x4 to register 2 in the same cycle as a new btn[2] press leaves register 2 at 0x4 and increments register 3.
REQ-030 SHALL verify that after writing 0xFFFFFFFF to register 3, one press gives register 3 = 0; and that with register 4 = 0, a press leaves registers 2 and 3 unchanged.
REQ-031 SHALL verify that rst pulled low mid-count clears douta and registers 1..3 to 0 in the same cycle and register 4 to 1.
REQ-032 SHALL verify that a read of address 9 returns 0 one cycle later, and that a write then read of register 0 returns the unchanged switch value.
